// File: rtl/video_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | video_pkg: shared defaults and timing bundle for the video pipeline  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package video_pkg;

    localparam int C_PIX_CLK_DIV = 4;
    localparam int C_ADDR_W      = 20;

    typedef struct packed {
        logic hde;
        logic vde;
        logic hsync;
        logic vsync;
    } sync_bus_t;

endpackage
`default_nettype wire

// File: rtl/sync_delay_line.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sync_delay_line: enabled WIDTH x DEPTH shift register, async clear   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module sync_delay_line #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [DEPTH-1:0][WIDTH-1:0] r_pipe;

    generate
        if (DEPTH == 1) begin : g_single
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_pipe <= '0;
                end else if (i_en) begin
                    r_pipe[0] <= i_d;
                end
            end
        end else begin : g_multi
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_pipe <= '0;
                end else if (i_en) begin
                    r_pipe <= {r_pipe[DEPTH-2:0], i_d};
                end
            end
        end
    endgenerate

    assign o_q = r_pipe[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/fb_addr_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fb_addr_gen: framebuffer read-address generator with pixel repeat,   |
// | line stride and pixel-step-aligned timing delay.  Revision: 1.0      |
// +----------------------------------------------------------------------+
module fb_addr_gen
    import video_pkg::*;
#(
    parameter int ADDR_W      = C_ADDR_W,
    parameter int PIX_CLK_DIV = C_PIX_CLK_DIV,
    parameter int PIPE_DELAY  = 8
) (
    input  logic              pclk,
    input  logic              reset_n,
    input  logic [3:0]        pc_ena,
    input  logic              hde,
    input  logic              vde,
    input  logic              hsync,
    input  logic              vsync,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [15:0]       stride,
    input  logic [3:0]        h_scale,
    input  logic [3:0]        v_scale,
    output logic              rd_req,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              frame_start,
    output logic              hde_d,
    output logic              vde_d,
    output logic              hsync_d,
    output logic              vsync_d
);

    logic [ADDR_W-1:0] r_line_base;
    logic [15:0]       r_stride;
    logic [3:0]        r_h_scale;
    logic [3:0]        r_v_scale;
    logic [11:0]       r_x_off;
    logic [3:0]        r_h_rep;
    logic [3:0]        r_v_rep;
    logic              r_prev_hde;
    logic              r_prev_vde;
    logic              r_seen;
    logic              r_armed;
    logic              r_first;

    logic              w_step;
    logic              w_de;
    logic              w_frame_ev;
    logic              w_line_start;
    logic              w_line_end;
    logic              w_issue;
    logic              w_first;
    logic [ADDR_W-1:0] w_line_base;
    logic [3:0]        w_h_scale;
    logic [11:0]       w_x;
    logic [3:0]        w_h_rep;
    logic [ADDR_W-1:0] w_addr;
    sync_bus_t         w_sync_in;
    sync_bus_t         w_sync_out;

    assign w_step       = (pc_ena == 4'd0) && (int'(pc_ena) <= PIX_CLK_DIV);
    assign w_de         = hde & vde;
    // r_seen keeps the first step after reset from mistaking a mid-frame vde for a rise
    assign w_frame_ev   = r_seen & vde & ~r_prev_vde;
    assign w_line_start = w_de & ~r_prev_hde;
    assign w_line_end   = ~hde & r_prev_hde & vde;

    // Frame/line-start values are forwarded so the request on that same step uses them
    assign w_line_base  = w_frame_ev ? base_addr : r_line_base;
    assign w_h_scale    = w_frame_ev ? h_scale : r_h_scale;
    assign w_first      = w_frame_ev | r_first;
    assign w_x          = w_line_start ? 12'd0 : r_x_off;
    assign w_h_rep      = w_line_start ? 4'd0 : r_h_rep;
    assign w_issue      = w_step & w_de & (r_armed | w_frame_ev);
    assign w_addr       = w_line_base + ADDR_W'(w_x);

    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
            r_line_base <= '0;
            r_stride    <= '0;
            r_h_scale   <= '0;
            r_v_scale   <= '0;
            r_x_off     <= '0;
            r_h_rep     <= '0;
            r_v_rep     <= '0;
            r_prev_hde  <= 1'b0;
            r_prev_vde  <= 1'b0;
            r_seen      <= 1'b0;
            r_armed     <= 1'b0;
            r_first     <= 1'b0;
            rd_req      <= 1'b0;
            rd_addr     <= '0;
            frame_start <= 1'b0;
        end else begin
            rd_req      <= 1'b0;
            frame_start <= 1'b0;
            if (w_step) begin
                r_seen     <= 1'b1;
                r_prev_hde <= hde;
                r_prev_vde <= vde;
                if (w_frame_ev) begin
                    r_line_base <= base_addr;
                    r_stride    <= stride;
                    r_h_scale   <= h_scale;
                    r_v_scale   <= v_scale;
                    r_v_rep     <= 4'd0;
                    r_armed     <= 1'b1;
                    r_first     <= 1'b1;
                end else if (w_line_end) begin
                    if (r_v_rep == r_v_scale) begin
                        r_v_rep     <= 4'd0;
                        r_line_base <= r_line_base + ADDR_W'(r_stride);
                    end else begin
                        r_v_rep <= r_v_rep + 4'd1;
                    end
                end
                if (w_issue) begin
                    rd_req      <= 1'b1;
                    rd_addr     <= w_addr;
                    frame_start <= w_first;
                    r_first     <= 1'b0;
                    if (w_h_rep == w_h_scale) begin
                        r_h_rep <= 4'd0;
                        r_x_off <= w_x + 12'd1;
                    end else begin
                        r_h_rep <= w_h_rep + 4'd1;
                        r_x_off <= w_x;
                    end
                end
            end
        end
    end

    assign w_sync_in = {hde, vde, hsync, vsync};

    sync_delay_line #(
        .WIDTH ($bits(sync_bus_t)),
        .DEPTH (PIPE_DELAY)
    ) u_sync_delay (
        .clk   (pclk),
        .rst_n (reset_n),
        .i_en  (w_step),
        .i_d   (w_sync_in),
        .o_q   (w_sync_out)
    );

    assign hde_d   = w_sync_out.hde;
    assign vde_d   = w_sync_out.vde;
    assign hsync_d = w_sync_out.hsync;
    assign vsync_d = w_sync_out.vsync;

endmodule
`default_nettype wire

// File: tb/tb_fb_addr_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_fb_addr_gen: self-checking bench for fb_addr_gen on a reduced     |
// | 16x6 active raster.  Revision: 1.0                                   |
// +----------------------------------------------------------------------+
module tb_fb_addr_gen;
    import video_pkg::*;

    localparam int ADDR_W      = 20;
    localparam int PIX_CLK_DIV = 4;
    localparam int PIPE_DELAY  = 8;
    localparam int HA = 16, HT = 24, VA = 6, VT = 9;
    localparam int BUDGET = 4000;

    logic              pclk = 1'b0;
    logic              reset_n = 1'b0;
    logic [3:0]        pc_ena = 4'd0;
    logic              hde = 1'b0, vde = 1'b0, hsync = 1'b0, vsync = 1'b0;
    logic [ADDR_W-1:0] base_addr = '0;
    logic [15:0]       stride = '0;
    logic [3:0]        h_scale = '0, v_scale = '0;
    logic              rd_req, frame_start, hde_d, vde_d, hsync_d, vsync_d;
    logic [ADDR_W-1:0] rd_addr;

    fb_addr_gen #(
        .ADDR_W      (ADDR_W),
        .PIX_CLK_DIV (PIX_CLK_DIV),
        .PIPE_DELAY  (PIPE_DELAY)
    ) dut (
        .pclk        (pclk),
        .reset_n     (reset_n),
        .pc_ena      (pc_ena),
        .hde         (hde),
        .vde         (vde),
        .hsync       (hsync),
        .vsync       (vsync),
        .base_addr   (base_addr),
        .stride      (stride),
        .h_scale     (h_scale),
        .v_scale     (v_scale),
        .rd_req      (rd_req),
        .rd_addr     (rd_addr),
        .frame_start (frame_start),
        .hde_d       (hde_d),
        .vde_d       (vde_d),
        .hsync_d     (hsync_d),
        .vsync_d     (vsync_d)
    );

    always #5 pclk = ~pclk;

    typedef struct {
        logic [ADDR_W-1:0] base;
        logic [15:0]       strd;
        logic [3:0]        hs;
        logic [3:0]        vs;
        int                exp_count;
        logic [ADDR_W-1:0] exp_last;
    } vec_t;

    int n_checks = 0, n_fail = 0;

    // raster generator state
    int pcnt = 0, hcnt = 0, vcnt = 0;
    bit stall_en = 0, stall_now = 0;

    // reference model state
    bit                m_seen, m_pvde, m_armed, m_first;
    logic [ADDR_W-1:0] m_base, m_addr;
    logic [15:0]       m_stride;
    logic [3:0]        m_hs, m_vs;
    sync_bus_t         m_hist[$];
    int                frames_started = 0, step_idx = 0;

    // observed DUT activity
    int                dut_frame_cnt = 0, dut_req_total = 0;
    logic [ADDR_W-1:0] dut_last = '0, dut_fs_addr = '0;
    int                meas = 0, meas_k = 0, meas_m = 0;
    logic              prev_hde_d = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_seen = 0; m_pvde = 0; m_armed = 0; m_first = 0;
        m_addr = '0;
        m_hist.delete();
        for (int i = 0; i < PIPE_DELAY; i++) m_hist.push_back('0);
    endtask

    task automatic drive();
        pc_ena = stall_now ? 4'($urandom_range(PIX_CLK_DIV + 1, 15)) : 4'(pcnt);
        hde    = (hcnt < HA);
        vde    = (vcnt < VA);
        hsync  = (hcnt >= 18) && (hcnt < 21);
        vsync  = (vcnt == 7);
    endtask

    task automatic cycle();
        bit        exp_req, exp_fs;
        sync_bus_t s;
        drive();
        @(posedge pclk);
        exp_req = 0;
        exp_fs  = 0;
        s = {hde, vde, hsync, vsync};
        if (!reset_n) begin
            model_reset();
        end else if (pc_ena == 4'd0) begin
            step_idx++;
            if (m_seen && vde && !m_pvde) begin
                m_base = base_addr; m_stride = stride; m_hs = h_scale; m_vs = v_scale;
                m_armed = 1; m_first = 1;
                frames_started++;
            end
            if (m_armed && hde && vde) begin
                m_addr = ADDR_W'(int'(m_base) + (vcnt / (int'(m_vs) + 1)) * int'(m_stride)
                                 + hcnt / (int'(m_hs) + 1));
                exp_req = 1;
                exp_fs  = m_first;
                m_first = 0;
            end
            m_pvde = vde;
            m_seen = 1;
            m_hist.push_front(s);
            void'(m_hist.pop_back());
        end
        #1;
        chk("rd_req", rd_req, exp_req);
        chk("frame_start", frame_start, exp_fs);
        chk("rd_addr", rd_addr, m_addr);
        chk("sync_d", {hde_d, vde_d, hsync_d, vsync_d}, m_hist[PIPE_DELAY-1]);
        if (frame_start === 1'b1) begin
            dut_fs_addr   = rd_addr;
            dut_frame_cnt = 0;
        end
        if (rd_req === 1'b1) begin
            dut_frame_cnt++;
            dut_req_total++;
            dut_last = rd_addr;
        end
        if (meas == 2 && hde_d === 1'b1 && prev_hde_d === 1'b0) begin
            meas_m = step_idx;
            meas   = 3;
        end
        prev_hde_d = hde_d;
        if (!stall_now) begin
            if (pcnt == 0) begin
                hcnt++;
                if (hcnt == HT) begin
                    hcnt = 0;
                    vcnt = (vcnt + 1) % VT;
                    if (meas == 1) begin
                        meas_k = step_idx;
                        meas   = 2;
                    end
                end
            end
            pcnt = (pcnt == PIX_CLK_DIV) ? 0 : pcnt + 1;
        end
        stall_now = stall_en && ($urandom_range(0, 7) == 0);
    endtask

    task automatic wait_fs();
        int start = frames_started;
        int n = 0;
        while (frames_started == start && n < BUDGET) begin cycle(); n++; end
        chk("wait_fs_timeout", (n < BUDGET), 1);
    endtask

    task automatic run_until_v(input int target);
        int n = 0;
        while (vcnt != target && n < BUDGET) begin cycle(); n++; end
        chk("run_until_v_timeout", (n < BUDGET), 1);
    endtask

    task automatic run_frame();
        wait_fs();
        run_until_v(VA);
    endtask

    task automatic set_cfg(input logic [ADDR_W-1:0] b, input logic [15:0] st,
                           input logic [3:0] hs, input logic [3:0] vs);
        base_addr = b; stride = st; h_scale = hs; v_scale = vs;
    endtask

    vec_t vecs[5];

    initial begin
        int n;
        int reqs_before;
        vecs[0] = '{base: 20'h01000, strd: 16'h0280, hs: 4'd0, vs: 4'd0, exp_count: 96, exp_last: 20'h01C8F};
        vecs[1] = '{base: 20'h01000, strd: 16'h0280, hs: 4'd1, vs: 4'd0, exp_count: 96, exp_last: 20'h01C87};
        vecs[2] = '{base: 20'h01000, strd: 16'h0280, hs: 4'd0, vs: 4'd1, exp_count: 96, exp_last: 20'h0150F};
        vecs[3] = '{base: 20'h01000, strd: 16'h0280, hs: 4'd2, vs: 4'd2, exp_count: 96, exp_last: 20'h01285};
        vecs[4] = '{base: 20'hFFFF8, strd: 16'h0010, hs: 4'd0, vs: 4'd0, exp_count: 96, exp_last: 20'h00057};

        model_reset();
        reset_n = 1'b0;
        repeat (4) cycle();
        reset_n = 1'b1;

        for (int i = 0; i < 5; i++) begin
            set_cfg(vecs[i].base, vecs[i].strd, vecs[i].hs, vecs[i].vs);
            run_frame();
            chk("tbl_count", dut_frame_cnt, vecs[i].exp_count);
            chk("tbl_last", dut_last, vecs[i].exp_last);
            chk("tbl_first", dut_fs_addr, vecs[i].base);
        end

        // base changes in the middle of a frame; only the next frame sees it
        set_cfg(20'h01000, 16'h0280, 4'd0, 4'd0);
        run_frame();
        wait_fs();
        run_until_v(3);
        base_addr = 20'h02000;
        run_until_v(VA);
        chk("midcfg_old_last", dut_last, 20'h01C8F);
        run_frame();
        chk("midcfg_new_first", dut_fs_addr, 20'h02000);
        chk("midcfg_new_last", dut_last, 20'h02C8F);

        // reset in the middle of a displayed line
        set_cfg(20'h03000, 16'h0280, 4'd0, 4'd0);
        run_frame();
        wait_fs();
        run_until_v(2);
        n = 0;
        while (hcnt != 7 && n < BUDGET) begin cycle(); n++; end
        chk("reset_pos_timeout", (n < BUDGET), 1);
        reset_n = 1'b0;
        #1;
        chk("rst_async_rd_req", rd_req, 0);
        chk("rst_async_rd_addr", rd_addr, 0);
        chk("rst_async_fs", frame_start, 0);
        chk("rst_async_sync_d", {hde_d, vde_d, hsync_d, vsync_d}, 0);
        model_reset();
        repeat (3) cycle();
        reset_n = 1'b1;
        reqs_before = dut_req_total;
        wait_fs();
        chk("post_reset_reqs", dut_req_total - reqs_before, 1);
        chk("post_reset_first", dut_fs_addr, 20'h03000);
        run_until_v(VA);

        // timing delay measured in pixel steps from a raw hde rise
        meas = 1;
        n = 0;
        while (meas != 3 && n < BUDGET) begin cycle(); n++; end
        chk("hde_d_timeout", (n < BUDGET), 1);
        chk("hde_d_delay_steps", meas_m - meas_k, PIPE_DELAY);

        // randomized configurations with non-step pc_ena values mixed in
        stall_en = 1;
        for (int i = 0; i < 6; i++) begin
            set_cfg(ADDR_W'($urandom), 16'($urandom), 4'($urandom_range(0, 15)),
                    4'($urandom_range(0, 15)));
            run_frame();
            chk("rand_count", dut_frame_cnt, HA * VA);
        end
        stall_en = 0;
        repeat (20) cycle();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
